// File: rtl/dd_cdc_pkg.sv
// dd_cdc_pkg: shared types and constants for the toggle-handshake bus crossing.
package dd_cdc_pkg;
  typedef enum logic {IDLE, WAIT_ACK} state_e;
  localparam int CNT_W = 16;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/dd_cdc_bus_tx_if.sv
// dd_cdc_bus_tx_if: handshake/bus bundle for dd_cdc_bus_tx.
// Source side:  data_i, valid_i, ready_o.
// Destination side: data_o, req_o, ack_i.
// Status: done_o, xfer_cnt_o, err_o.
// Modports: master drives the source side and the ack; slave is the block itself.
interface dd_cdc_bus_tx_if
  import dd_cdc_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_i, data_o;
  logic             valid_i, ready_o, req_o, ack_i, done_o, err_o;
  logic [CNT_W-1:0] xfer_cnt_o;
  modport master(output data_i, valid_i, ack_i,
                 input  ready_o, data_o, req_o, done_o, xfer_cnt_o, err_o);
  modport slave (input  data_i, valid_i, ack_i,
                 output ready_o, data_o, req_o, done_o, xfer_cnt_o, err_o);
endinterface

// File: rtl/dd_sync.sv
// dd_sync: STAGES-deep flop synchronizer with async active-low reset.
// Ports: clk, rst_ni (async, active low), d_i (async input), q_o (synchronized).
module dd_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) sync_q <= {STAGES{RST_VAL}};
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/dd_cdc_bus_tx.sv
// dd_cdc_bus_tx: source half of a toggle-handshake bus crossing.
// Ports: clk, rst (async, active high), bus (dd_cdc_bus_tx_if.slave):
//   data_i/valid_i/ready_o accept a word, data_o/req_o present it to the
//   destination, ack_i returns the toggle, done_o/xfer_cnt_o report completions,
//   err_o pulses on timeout.
// Option: DD_CDC_BUS_TX_TIMEOUT_EN enables the WAIT_ACK timeout; otherwise err_o is 0.
module dd_cdc_bus_tx
  import dd_cdc_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter int               SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter logic [WIDTH-1:0] RST_VAL        = '0,
  parameter int               TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst,
  dd_cdc_bus_tx_if.slave  bus
);
  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             req_q, done_q, ack_sync;
  logic [CNT_W-1:0] xfer_q;
`ifdef DD_CDC_BUS_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_q;
  logic             err_q;
`endif
  dd_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ack_sync (
    .clk   (clk),
    .rst_ni(~rst),
    .d_i   (bus.ack_i),
    .q_o   (ack_sync)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      data_q  <= RST_VAL;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      xfer_q  <= '0;
`ifdef DD_CDC_BUS_TX_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef DD_CDC_BUS_TX_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      if (state_q == IDLE) begin
        if (bus.valid_i) begin
          data_q  <= bus.data_i;
          req_q   <= ~req_q;
          state_q <= WAIT_ACK;
`ifdef DD_CDC_BUS_TX_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
      end else if (ack_sync == req_q) begin
        state_q <= IDLE;
        done_q  <= 1'b1;
        xfer_q  <= xfer_q + 1'b1;
      end
`ifdef DD_CDC_BUS_TX_TIMEOUT_EN
      // req_q stays toggled on abort; the next accept toggles it again
      else if (tmo_q == TO_LAST) begin
        state_q <= IDLE;
        err_q   <= 1'b1;
      end else tmo_q <= tmo_q + 1'b1;
`endif
    end
  assign bus.ready_o    = state_q == IDLE;
  assign bus.data_o     = data_q;
  assign bus.req_o      = req_q;
  assign bus.done_o     = done_q;
  assign bus.xfer_cnt_o = xfer_q;
`ifdef DD_CDC_BUS_TX_TIMEOUT_EN
  assign bus.err_o      = err_q;
`else
  assign bus.err_o      = 1'b0;
`endif
endmodule

// File: tb/tb_dd_cdc_bus_tx.sv
// tb_dd_cdc_bus_tx: directed self-checking bench for dd_cdc_bus_tx.
module tb_dd_cdc_bus_tx;
  import dd_cdc_pkg::*;
`ifdef DD_CDC_BUS_TX_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [7:0] RV = 8'h5A;
  logic clk = 1'b0, rst = 1'b1, loop = 1'b0, ack_man = 1'b0;
  int checks = 0, failures = 0;
  dd_cdc_bus_tx_if #(.WIDTH(8)) bus();
  assign bus.ack_i = loop ? bus.req_o : ack_man;
  dd_cdc_bus_tx #(.WIDTH(8), .SYNC_STAGES(2), .RST_VAL(RV), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; loop = 1'b0; ack_man = 1'b0; bus.valid_i = 1'b0; bus.data_i = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.valid_i = 1'b0; bus.data_i = '0; loop = 1'b0; ack_man = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
    checks++; if (bus.req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.req_o); end
    checks++; if (bus.data_o !== RV) begin failures++; $display("FAIL reset_data got=%h exp=%h", bus.data_o, RV); end
    checks++; if (bus.xfer_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.xfer_cnt_o); end
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
  endtask

  task automatic test_single();
    do_reset();
    loop = 1'b1; bus.data_i = 8'hA5; bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    checks++; if (bus.req_o !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", bus.req_o); end
    checks++; if (bus.data_o !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", bus.data_o); end
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", bus.ready_o); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (bus.done_o !== (i == 3)) begin failures++; $display("FAIL single_done E%0d got=%b exp=%b", i, bus.done_o, i == 3); end
    end
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL single_ready_e3 got=%b exp=1", bus.ready_o); end
    checks++; if (bus.xfer_cnt_o !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", bus.xfer_cnt_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3] = '{8'h11, 8'h22, 8'h33};
    int acc [3] = '{-1, -1, -1};
    int n = 0;
    logic prev = 1'b0;
    do_reset();
    loop = 1'b1; bus.data_i = w[0]; bus.valid_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.req_o !== prev) begin
        if (n < 3) begin
          acc[n] = c;
          checks++; if (bus.data_o !== w[n]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", n, bus.data_o, w[n]); end
          checks++; if (bus.req_o !== (n % 2 == 0)) begin failures++; $display("FAIL b2b_req%0d got=%b exp=%b", n, bus.req_o, n % 2 == 0); end
        end
        prev = bus.req_o;
        n++;
        bus.data_i = (n < 3) ? w[n] : 8'h00;
        if (n >= 3) bus.valid_i = 1'b0;
      end
    end
    checks++; if (n != 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (acc[i] != 4 * i) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, acc[i], 4 * i); end
    end
    checks++; if (bus.xfer_cnt_o !== 16'd3) begin failures++; $display("FAIL b2b_cnt got=%0d exp=3", bus.xfer_cnt_o); end
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", bus.ready_o); end
  endtask

`ifndef DD_CDC_BUS_TX_TIMEOUT_EN
  task automatic test_delayed_ack();
    do_reset();
    bus.data_i = 8'h3C; bus.valid_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      bus.data_i = 8'(i * 7 + 1); bus.valid_i = 1'b1;
      @(negedge clk);
      checks++; if (bus.ready_o !== 1'b0 || bus.data_o !== 8'h3C || bus.done_o !== 1'b0) begin
        failures++; $display("FAIL delay_hold c%0d ready=%b data=%h done=%b exp 0/3c/0", i, bus.ready_o, bus.data_o, bus.done_o);
      end
    end
    ack_man = 1'b1; bus.valid_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (bus.done_o !== (i == 3)) begin failures++; $display("FAIL delay_done E%0d got=%b exp=%b", i, bus.done_o, i == 3); end
    end
    checks++; if (bus.data_o !== 8'h3C) begin failures++; $display("FAIL delay_data got=%h exp=3c", bus.data_o); end
    checks++; if (bus.xfer_cnt_o !== 16'd1) begin failures++; $display("FAIL delay_cnt got=%0d exp=1", bus.xfer_cnt_o); end
  endtask
`endif

  task automatic test_rst_mid();
    do_reset();
    loop = 1'b1; bus.data_i = 8'h44; bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (3) @(negedge clk);
    ack_man = 1'b1; loop = 1'b0; bus.data_i = 8'h99; bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    checks++; if (bus.ready_o !== 1'b0 || bus.req_o !== 1'b0 || bus.xfer_cnt_o !== 16'd1) begin
      failures++; $display("FAIL rstmid_pre ready=%b req=%b cnt=%0d exp 0/0/1", bus.ready_o, bus.req_o, bus.xfer_cnt_o);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1; ack_man = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus.ready_o); end
    checks++; if (bus.data_o !== RV) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", bus.data_o, RV); end
    checks++; if (bus.xfer_cnt_o !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", bus.xfer_cnt_o); end
    checks++; if (bus.req_o !== 1'b0 || bus.done_o !== 1'b0) begin failures++; $display("FAIL rstmid_req_done req=%b done=%b exp 0/0", bus.req_o, bus.done_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.done_o !== 1'b0 || bus.ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_after c%0d done=%b ready=%b exp 0/1", i, bus.done_o, bus.ready_o); end
    end
  endtask

`ifdef DD_CDC_BUS_TX_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.data_i = 8'hC3; bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++; if (bus.err_o !== (i == 16) || bus.ready_o !== (i == 16)) begin
        failures++; $display("FAIL tmo_E%0d err=%b ready=%b exp=%b", i, bus.err_o, bus.ready_o, i == 16);
      end
    end
    checks++; if (bus.xfer_cnt_o !== 16'd0 || bus.done_o !== 1'b0) begin failures++; $display("FAIL tmo_cnt cnt=%0d done=%b exp 0/0", bus.xfer_cnt_o, bus.done_o); end
    @(negedge clk);
    checks++; if (bus.err_o !== 1'b0 || bus.req_o !== 1'b1) begin failures++; $display("FAIL tmo_after err=%b req=%b exp 0/1", bus.err_o, bus.req_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef DD_CDC_BUS_TX_TIMEOUT_EN
    test_timeout();
`else
    test_delayed_ack();
`endif
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dd_cdc_bus_tx.md
# dd_cdc_bus_tx

Source-side half of a toggle-handshake bus crossing. Accepts a WIDTH-bit word in the local clock domain and holds it stable on `data_o`. Signals the transfer by toggling the level `req_o`, then waits for the destination's returned toggle `ack_i` (asynchronous, synchronized internally) before accepting the next word. Sits at the sending end of any multi-bit clock-domain crossing; the destination end samples `data_o` after synchronizing `req_o`.

## Interface
- `WIDTH`, 8: data word width.
- `SYNC_STAGES`, 2: flop stages on `ack_i` (≥2).
- `RST_VAL`, 0: reset value of `data_o`.
- `TIMEOUT_CYCLES`, 1024: WAIT_ACK abort limit; used only when `DD_CDC_BUS_TX_TIMEOUT_EN` is defined.
- `clk`  in  1  sole clock; all logic is posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_i`  in  WIDTH  word to send.
- `valid_i`  in  1  word present on `data_i`.
- `ready_o`  out  1  block can accept; transfer occurs on an edge where `valid_i & ready_o`.
- `data_o`  out  WIDTH  registered bus to destination; stable while in WAIT_ACK.
- `req_o`  out  1  request toggle, registered.
- `ack_i`  in  1  acknowledge toggle from destination domain (async).
- `done_o`  out  1  one-cycle pulse when an ack completes a transfer.
- `xfer_cnt_o`  out  16  completed-transfer count, wraps 0xFFFF→0.
- `err_o`  out  1  one-cycle timeout pulse (tied 0 when the feature is out).

## Operation
- Reset values: `data_o`=RST_VAL, `req_o`=0, all ack sync flops=0, state=IDLE, `done_o`=0, `xfer_cnt_o`=0, `err_o`=0. `ready_o`=1 as the state decode.
- `ack_sync` is the output of the SYNC_STAGES-deep flop chain on `ack_i`.
- `ready_o` = (state == IDLE), combinational decode of the state register.
- IDLE:
  - `valid_i=1` on an edge: `data_o<=data_i`, `req_o<=~req_o`, go to WAIT_ACK.
  - Otherwise hold.
- WAIT_ACK:
  - On an edge with `ack_sync == req_o`: go to IDLE, `done_o<=1`, `xfer_cnt_o<=xfer_cnt_o+1` (mod 2^16).
  - `valid_i` is ignored; `data_o` and `req_o` are held.
- `done_o` and `err_o` are deasserted on every other edge.
- Reset mid-transfer aborts immediately; no completion pulse is generated. The destination must be reset together with this block so that the toggle levels agree.

## Timing
- Accept edge E0: `req_o` and `data_o` update at E0.
- `ack_sync` follows `ack_i` by SYNC_STAGES edges.
- The compare is sampled the edge after that, so the state returns to IDLE and `done_o` rises one edge after `ack_sync` matches.
- With `ack_i` wired directly to `req_o`, the minimum accept-to-accept interval is SYNC_STAGES+2 cycles (4 with the default).
- `data_o` never changes while `req_o != ack_sync`.

## Configuration
- `DD_CDC_BUS_TX_TIMEOUT_EN` defined:
  - A 16-bit cycle counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYCLES-1 without an ack: go to IDLE, pulse `err_o` for one cycle.
  - No `done_o` pulse and no count increment on timeout.
  - `req_o` is left at its toggled level; the next accepted word toggles it again.
- Not defined: no counter, `err_o` is tied 0, WAIT_ACK waits indefinitely.

## Structure
- Shared package `dd_cdc_pkg` holds:
  - the state enum (IDLE, WAIT_ACK);
  - the 16-bit count width constant;
  - the default SYNC_STAGES constant.
- Sub-module: instantiate the existing `dd_sync` for `ack_i`.
  - WIDTH=1, STAGES=SYNC_STAGES, RST_VAL=0.
  - Its active-low reset input is driven with `~rst`.

## Test plan
- Reset, then hold `valid_i`=0: `ready_o`=1, `req_o`=0, `data_o`=RST_VAL, `xfer_cnt_o`=0.
- Loopback `ack_i=req_o`, send 0xA5 at E0: `req_o`=1 at E0, `data_o`=0xA5, `done_o` at E3, next accept at E4, `xfer_cnt_o`=1.
- Stream 3 words back-to-back in loopback: accepts spaced exactly 4 cycles apart, `req_o` toggles 1,0,1, `xfer_cnt_o`=3.
- Delay the ack by 50 cycles and drive new `data_i` values during WAIT_ACK: `ready_o`=0 and `data_o` stays at the first word; `done_o` fires 3 edges after the ack toggle.
- Assert `rst` while in WAIT_ACK: all outputs return to reset values asynchronously, no `done_o`, `xfer_cnt_o` cleared.
- With `DD_CDC_BUS_TX_TIMEOUT_EN` defined and TIMEOUT_CYCLES=16, never ack: `err_o` pulses 16 cycles after entering WAIT_ACK, `ready_o` returns to 1, `xfer_cnt_o` unchanged.
